// File: rtl/load_align_unit.sv
// Misaligned load unit: fetches one or two D-cache lines, extracts and extends the loaded value.
// Result is registered; resultValid is held until the consumer takes it.
package load_align_pkg;
  localparam int DCACHE_LINE_SIZE = 16;

  typedef enum logic [3:0] {
    LS_BYTE   = 4'd0,
    LS_HALF   = 4'd1,
    LS_WORD   = 4'd2,
    LS_DOUBLE = 4'd3,
    LS_UBYTE  = 4'd4,
    LS_UHALF  = 4'd5,
    LS_UWORD  = 4'd6,
    LS_FPWORD = 4'd7,
    LS_NONE   = 4'd15
  } LoadStoreType;
endpackage

module load_align_unit
  import load_align_pkg::*;
#(
  parameter int LINE_SIZE  = DCACHE_LINE_SIZE,
  parameter int LINE_WIDTH = LINE_SIZE * 8,
  parameter int ADDR_WIDTH = $clog2(LINE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  LoadStoreType          reqLoadStoreType,
  output logic                  lineReqValid,
  output logic                  lineReqSecond,
  input  logic                  lineRespValid,
  input  logic [LINE_WIDTH-1:0] lineRespData,
  output logic                  resultValid,
  input  logic                  resultReady,
  output logic [63:0]           resultValue
);

  typedef enum logic [1:0] {Idle, WaitFirst, WaitSecond, Done} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  LoadStoreType          type_q, type_d;
  logic [LINE_WIDTH-1:0] line0_q, line0_d;
  logic [63:0]           result_q, result_d;
  logic                  req_ready_q, req_ready_d;
  logic                  line_req_vld_q, line_req_vld_d;
  logic                  line_req_second_q, line_req_second_d;
  logic                  result_vld_q, result_vld_d;
  logic                  crosses_line;

  function automatic logic [3:0] size_of(input LoadStoreType t);
    case (t)
      LS_BYTE, LS_UBYTE:           size_of = 4'd1;
      LS_HALF, LS_UHALF:           size_of = 4'd2;
      LS_WORD, LS_UWORD, LS_FPWORD: size_of = 4'd4;
      LS_DOUBLE:                   size_of = 4'd8;
      default:                     size_of = 4'd0;
    endcase
  endfunction

  // Bytes past the end of line0 come from line1, so the pair is treated as one 2-line window.
  function automatic logic [63:0] align_extend(input LoadStoreType t,
                                               input logic [ADDR_WIDTH-1:0] a,
                                               input logic [LINE_WIDTH-1:0] l0,
                                               input logic [LINE_WIDTH-1:0] l1);
    logic [2*LINE_WIDTH-1:0] window;
    logic [63:0]             raw;
    logic [3:0]              sz;
    sz     = size_of(t);
    window = {l1, l0} >> {a, 3'b000};
    raw    = window[63:0];
    for (int k = 0; k < 8; k++) begin
      if (k >= int'(sz)) raw[8*k +: 8] = 8'h00;
    end
    case (t)
      LS_BYTE:   align_extend = {{56{raw[7]}}, raw[7:0]};
      LS_HALF:   align_extend = {{48{raw[15]}}, raw[15:0]};
      LS_WORD:   align_extend = {{32{raw[31]}}, raw[31:0]};
      LS_FPWORD: align_extend = {32'hFFFF_FFFF, raw[31:0]};
      default:   align_extend = raw;
    endcase
  endfunction

  assign crosses_line = (int'(addr_q) + int'(size_of(type_q))) > LINE_SIZE;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    type_d   = type_q;
    line0_d  = line0_q;
    result_d = result_q;
    case (state_q)
      Idle: begin
        if (reqValid) begin
          addr_d  = reqAddr;
          type_d  = reqLoadStoreType;
          state_d = WaitFirst;
        end
      end
      WaitFirst: begin
        if (lineRespValid) begin
          line0_d = lineRespData;
          if (crosses_line) begin
            state_d = WaitSecond;
          end else begin
            state_d  = Done;
            result_d = align_extend(type_q, addr_q, lineRespData, '0);
          end
        end
      end
      WaitSecond: begin
        if (lineRespValid) begin
          state_d  = Done;
          result_d = align_extend(type_q, addr_q, line0_q, lineRespData);
        end
      end
      Done: begin
        if (resultReady) state_d = Idle;
      end
      default: state_d = Idle;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    req_ready_d       = (state_d == Idle);
    line_req_vld_d    = (state_d == WaitFirst) || (state_d == WaitSecond);
    line_req_second_d = (state_d == WaitSecond);
    result_vld_d      = (state_d == Done);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q           <= Idle;
      addr_q            <= '0;
      type_q            <= LS_BYTE;
      line0_q           <= '0;
      result_q          <= '0;
      req_ready_q       <= 1'b1;
      line_req_vld_q    <= 1'b0;
      line_req_second_q <= 1'b0;
      result_vld_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      type_q            <= type_d;
      line0_q           <= line0_d;
      result_q          <= result_d;
      req_ready_q       <= req_ready_d;
      line_req_vld_q    <= line_req_vld_d;
      line_req_second_q <= line_req_second_d;
      result_vld_q      <= result_vld_d;
    end
  end

  assign reqReady      = req_ready_q;
  assign lineReqValid  = line_req_vld_q;
  assign lineReqSecond = line_req_second_q;
  assign resultValid   = result_vld_q;
  assign resultValue   = result_q;

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 The block SHALL have parameter LINE_SIZE, default DCACHE_LINE_SIZE, giving the D-cache line size in bytes (power of two, >= 8).
REQ-002 The block SHALL have parameter LINE_WIDTH, default LINE_SIZE*8, giving the line width in bits.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(LINE_SIZE), giving the byte-offset width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rstN, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port reqValid, input, 1 bit: a load request is present.
REQ-007 The block SHALL have port reqReady, output, 1 bit: the block accepts a request this cycle.
REQ-008 The block SHALL have port reqAddr, input, ADDR_WIDTH bits: byte offset of the load within the first line.
REQ-009 The block SHALL have port reqLoadStoreType, input, LoadStoreType: access type of the load.
REQ-010 The block SHALL have port lineReqValid, output, 1 bit: the block requests a line from the cache.
REQ-011 The block SHALL have port lineReqSecond, output, 1 bit: 0 requests the addressed line, 1 requests the next sequential line.
REQ-012 The block SHALL have port lineRespValid, input, 1 bit: a single-cycle pulse marking valid lineRespData.
REQ-013 The block SHALL have port lineRespData, input, LINE_WIDTH bits: returned line, byte i at bits [8i+7:8i].
REQ-014 The block SHALL have port resultValid, output, 1 bit: resultValue is valid.
REQ-015 The block SHALL have port resultReady, input, 1 bit: the consumer takes the result.
REQ-016 The block SHALL have port resultValue, output, uint64_t: the aligned and extended load value.

Function
REQ-017 The FSM SHALL have exactly four states: Idle, WaitFirst, WaitSecond, Done.
REQ-018 reqReady SHALL be 1 only in Idle; a request is accepted on (reqValid && reqReady), which SHALL register addr and type and move the FSM to WaitFirst.
REQ-019 The access size SHALL be: Byte/UnsignedByte=1; HalfWord/UnsignedHalfWord=2; Word/UnsignedWord/FpWord=4; DoubleWord=8; any other type=0.
REQ-020 lineReqValid SHALL be 1 in WaitFirst (lineReqSecond=0) and in WaitSecond (lineReqSecond=1), and 0 otherwise.
REQ-021 In WaitFirst, lineRespValid SHALL capture line0 and move the FSM to WaitSecond if addr+size > LINE_SIZE, else to Done.
REQ-022 In WaitSecond, lineRespValid SHALL capture line1 and move the FSM to Done.
REQ-023 Byte k (k < size) of the raw value SHALL be line0[addr+k] when addr+k < LINE_SIZE, else line1[addr+k-LINE_SIZE]; bytes k >= size SHALL be 0.
REQ-024 Extension SHALL sign-extend Byte, HalfWord and Word from the top loaded bit.
REQ-025 Extension SHALL zero-extend the Unsigned types.
REQ-026 Extension SHALL force resultValue[63:32] to 32'hFFFF_FFFF for FpWord (NaN-boxing).
REQ-027 DoubleWord SHALL pass through without extension.
REQ-028 A size-0 type SHALL produce resultValue 0 after one fetch.
REQ-029 resultValue SHALL be registered, and resultValid SHALL be 1 exactly in Done, starting the cycle after the final lineRespValid; minimum latency from accept to resultValid SHALL be 2 cycles for one line and 3 cycles for two lines.
REQ-030 In Done, resultValue SHALL be held stable until resultReady=1; (resultValid && resultReady) SHALL return the FSM to Idle.
REQ-031 No new request SHALL be accepted in the handshake cycle; the next acceptance is no earlier than the following cycle.
REQ-032 lineRespValid in Idle or Done SHALL be ignored, with no state or data change.
REQ-033 reqValid outside Idle SHALL be ignored and SHALL NOT be acknowledged.
REQ-034 The block SHALL never issue more than one line request per state visit.

Reset
REQ-035 While rstN=0, the FSM SHALL be Idle and all registered data 0, independent of clk.
REQ-036 While rstN=0, outputs SHALL be: reqReady=1, lineReqValid=0, lineReqSecond=0, resultValid=0, resultValue=0.
REQ-037 Reset mid-operation SHALL abandon the transaction, and a late lineRespValid after reset release SHALL be ignored.

Verification (LINE_SIZE=16)
REQ-038 Scenario 1: Byte, addr 3, line0 byte3=8'h80 -> one fetch, resultValue=64'hFFFF_FFFF_FFFF_FF80, resultValid 2 cycles after accept when the response arrives the cycle after accept.
REQ-039 Scenario 2: UnsignedHalfWord, addr 14, bytes14/15=8'h34/8'h92 -> one fetch, resultValue=64'h0000_0000_0000_9234.
REQ-040 Scenario 3: Word, addr 14, line0[14..15]=11,22, line1[0..1]=33,44 -> two fetches (second with lineReqSecond=1), resultValue=64'h0000_0000_4433_2211.
REQ-041 Scenario 4: DoubleWord, addr 8, resultReady held 0 for 3 cycles -> resultValid and resultValue stable all 3 cycles, Idle the cycle after the handshake.
REQ-042 Scenario 5: FpWord, addr 0, bytes0..3=00,00,80,3F -> resultValue=64'hFFFF_FFFF_3F80_0000.
REQ-043 Scenario 6: rstN pulsed low in WaitSecond, then lineRespValid after release -> outputs at reset values, response ignored, next request processed correctly.
